inst_mem_loader: RTL and testbench

- Boot-time writer for the 8-bit processor's instruction memory: accepts a byte stream over a valid/ready handshake and writes it into instruction memory through a one-cycle write port.
- Holds the processor core in reset (cpu_hold) until a complete, checksum-verified program is loaded.
- Sits between the board byte source (UART/bench FIFO) and the instruction memory write side; the processor's PC/fetch path is the reader.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/loader_timeout.sv | 33 +++
 rtl/inst_mem_loader.sv | 158 +++++++++++++++
 tb/tb_inst_mem_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state encoding, default frame parameters and the checksum step.
package loader_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [7:0]  DEF_BASE_ADDR = 8'h00;
    localparam logic [15:0] DEF_TIMEOUT   = 16'd1000;

    // Running frame checksum: plain modulo-256 byte sum.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle watchdog. Reloaded on frame entry and on every accepted
// byte; counts down while a frame is active and flags expiry at zero.
module loader_timeout #(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    logic [15:0] cnt_r;

    // Down-counter: load has priority, then decrement while enabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= 16'd0;
        end else if (load) begin
            cnt_r <= TIMEOUT - 16'd1;
        end else if (enable && (cnt_r != 16'd0)) begin
            cnt_r <= cnt_r - 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expiry is only meaningful while a frame is in progress.
    always_comb begin
        expired = enable && (cnt_r == 16'd0);
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot-time instruction-memory loader: receives LEN / payload / CSUM frames
// over valid/ready, writes the payload through a one-cycle write port and
// keeps the CPU in reset until a checksum-verified frame has landed.
module inst_mem_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [15:0] TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        count
);

    logic [2:0]        state_r;
    logic [2:0]        state_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              frame_start_s;
    logic              expired_s;
    logic [7:0]        len_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        acc_r;
    logic [7:0]        count_r;
    logic              done_r;
    logic              error_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        mem_wdata_r;

    // Handshake and frame-entry qualifiers derived from the current state.
    always_comb begin
        in_ready_s    = (state_r == S_LEN) || (state_r == S_DATA) || (state_r == S_CSUM);
        accept_s      = in_valid && in_ready_s;
        frame_start_s = start && ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERR));
    end

    loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .load    (accept_s || frame_start_s),
        .enable  (in_ready_s),
        .expired (expired_s)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an accepted byte always wins over a same-cycle expiry.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_s = S_LEN;
                else       state_s = state_r;
            end
            S_LEN: begin
                if (accept_s)       state_s = (in_data == 8'd0) ? S_ERR : S_DATA;
                else if (expired_s) state_s = S_ERR;
                else                state_s = S_LEN;
            end
            S_DATA: begin
                if (accept_s)       state_s = (count_r == (len_r - 8'd1)) ? S_CSUM : S_DATA;
                else if (expired_s) state_s = S_ERR;
                else                state_s = S_DATA;
            end
            S_CSUM: begin
                if (accept_s)       state_s = (in_data == acc_r) ? S_DONE : S_ERR;
                else if (expired_s) state_s = S_ERR;
                else                state_s = S_CSUM;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode: handshake, busy and CPU hold follow the state register.
    always_comb begin
        in_ready  = in_ready_s;
        busy      = in_ready_s;
        cpu_hold  = (state_r != S_DONE);
        mem_we    = mem_we_r;
        mem_addr  = mem_addr_r;
        mem_wdata = mem_wdata_r;
        done      = done_r;
        error     = error_r;
        count     = count_r;
    end

    // Memory write port: one strobe the cycle after each payload acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 8'd0;
        end else begin
            mem_we_r <= (state_r == S_DATA) && accept_s;
            if ((state_r == S_DATA) && accept_s) begin
                mem_addr_r  <= addr_r;
                mem_wdata_r <= in_data;
            end
        end
    end

    // Frame bookkeeping: length, write pointer (wraps freely), checksum, count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_r   <= 8'd0;
            addr_r  <= {ADDR_W{1'b0}};
            acc_r   <= 8'd0;
            count_r <= 8'd0;
        end else if (frame_start_s) begin
            acc_r   <= 8'd0;
            count_r <= 8'd0;
        end else if ((state_r == S_LEN) && accept_s && (in_data != 8'd0)) begin
            len_r  <= in_data;
            addr_r <= BASE_ADDR;
        end else if ((state_r == S_DATA) && accept_s) begin
            addr_r  <= addr_r + ADDR_W'(1);
            acc_r   <= csum_add(acc_r, in_data);
            count_r <= count_r + 8'd1;
        end
    end

    // Sticky status flags, cleared when a new frame begins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else if (frame_start_s) begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            if ((state_r == S_CSUM) && (state_s == S_DONE)) done_r <= 1'b1;
            if ((state_r != S_ERR) && (state_s == S_ERR))   error_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader. Two instances (base 00 and base FE,
// both with an 8-cycle idle timeout) see the same byte stream; expected writes
// are queued when bytes are accepted and a monitor checks every mem_we pulse.
module tb_inst_mem_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready0, mem_we0, cpu_hold0, busy0, done0, error0;
    logic [7:0]  mem_addr0, mem_wdata0, count0;
    logic        in_ready1, mem_we1, cpu_hold1, busy1, done1, error1;
    logic [7:0]  mem_addr1, mem_wdata1, count1;

    logic [31:0] cyc = 32'd0;
    wr_t         q0[$];
    wr_t         q1[$];
    wr_t         e0, e1;
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam logic [7:0] BASE0 = 8'h00;
    localparam logic [7:0] BASE1 = 8'hFE;

    inst_mem_loader #(.ADDR_W(8), .BASE_ADDR(BASE0), .TIMEOUT(16'd8)) dut0 (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .error(error0), .count(count0)
    );

    inst_mem_loader #(.ADDR_W(8), .BASE_ADDR(BASE1), .TIMEOUT(16'd8)) dut1 (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .error(error1), .count(count1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic h, input logic b, input logic [7:0] c);
        check({tag, "_done0"},  done0,     d);
        check({tag, "_error0"}, error0,    e);
        check({tag, "_hold0"},  cpu_hold0, h);
        check({tag, "_busy0"},  busy0,     b);
        check({tag, "_count0"}, count0,    c);
        check({tag, "_done1"},  done1,     d);
        check({tag, "_error1"}, error1,    e);
        check({tag, "_count1"}, count1,    c);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready0"}, in_ready0,  1'b0);
        check({tag, "_we0"},    mem_we0,    1'b0);
        check({tag, "_addr0"},  mem_addr0,  8'h00);
        check({tag, "_wdata0"}, mem_wdata0, 8'h00);
        check({tag, "_addr1"},  mem_addr1,  8'h00);
        check({tag, "_hold1"},  cpu_hold1,  1'b1);
        check_status(tag, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Offer one byte; optionally precede it with an idle (valid low) cycle.
    task automatic send(input logic [7:0] b, input logic pay, input logic [7:0] off, input logic gap);
        int waited;
        wr_t w;
        waited = 0;
        if (gap) begin
            @(negedge clock);
            in_valid = 1'b0;
            #1;
            check("ready_in_gap", in_ready0, 1'b1);
        end
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        while (!in_ready0 && waited < 50) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (!in_ready0) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_wait: in_ready 0 after %0d cycles, required 1", waited);
            in_valid = 1'b0;
        end else begin
            if (pay) begin
                w.data = b;
                w.cyc  = cyc + 32'd1;
                w.addr = BASE0 + off;
                q0.push_back(w);
                w.addr = BASE1 + off;
                q1.push_back(w);
            end
            @(posedge clock);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Monitor: every write strobe must match the next queued expectation.
    always @(posedge clock) begin
        #1;
        if (mem_we0) begin
            n_checks++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL wr0_unexpected: addr %0h data %0h, required no write", mem_addr0, mem_wdata0);
            end else begin
                e0 = q0.pop_front();
                if (mem_addr0 !== e0.addr || mem_wdata0 !== e0.data || cyc !== e0.cyc) begin
                    n_fail++;
                    $display("FAIL wr0: got addr %0h data %0h cyc %0d, expected addr %0h data %0h cyc %0d",
                             mem_addr0, mem_wdata0, cyc, e0.addr, e0.data, e0.cyc);
                end
            end
        end
        if (mem_we1) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL wr1_unexpected: addr %0h data %0h, required no write", mem_addr1, mem_wdata1);
            end else begin
                e1 = q1.pop_front();
                if (mem_addr1 !== e1.addr || mem_wdata1 !== e1.data || cyc !== e1.cyc) begin
                    n_fail++;
                    $display("FAIL wr1: got addr %0h data %0h cyc %0d, expected addr %0h data %0h cyc %0d",
                             mem_addr1, mem_wdata1, cyc, e1.addr, e1.data, e1.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clock);
        #1;
        check_reset_outputs("rst");
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check("held_after_reset", cpu_hold0, 1'b1);

        // Happy path: A1+22+3F = 0x102 -> checksum 02.
        pulse_start();
        check("busy_after_start", busy0, 1'b1);
        check("ready_in_len", in_ready0, 1'b1);
        send(8'h03, 1'b0, 8'd0, 1'b0);
        send(8'hA1, 1'b1, 8'd0, 1'b0);
        send(8'h22, 1'b1, 8'd1, 1'b0);
        send(8'h3F, 1'b1, 8'd2, 1'b0);
        send(8'h02, 1'b0, 8'd0, 1'b0);
        check_status("happy", 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        check("happy_hold1", cpu_hold1, 1'b0);

        // Bad checksum: writes still happen, frame ends in error.
        pulse_start();
        check("restart_clears_done", done0, 1'b0);
        check("restart_holds_cpu", cpu_hold0, 1'b1);
        send(8'h03, 1'b0, 8'd0, 1'b0);
        send(8'hA1, 1'b1, 8'd0, 1'b0);
        send(8'h22, 1'b1, 8'd1, 1'b0);
        send(8'h3F, 1'b1, 8'd2, 1'b0);
        send(8'h03, 1'b0, 8'd0, 1'b0);
        check_status("badcsum", 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);

        // Zero length: immediate error, no writes.
        pulse_start();
        check("restart_clears_error", error0, 1'b0);
        send(8'h00, 1'b0, 8'd0, 1'b0);
        check_status("zerolen", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        repeat (2) @(negedge clock);

        // Backpressure with idle gaps; instance 1 wraps FE, FF, 00.
        pulse_start();
        send(8'h03, 1'b0, 8'd0, 1'b0);
        send(8'h11, 1'b1, 8'd0, 1'b1);
        send(8'h22, 1'b1, 8'd1, 1'b1);
        send(8'h33, 1'b1, 8'd2, 1'b1);
        send(8'h66, 1'b0, 8'd0, 1'b1);
        check_status("wrap", 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);

        // Timeout: still busy after 7 idle cycles, error on the 8th.
        pulse_start();
        send(8'h02, 1'b0, 8'd0, 1'b0);
        send(8'h55, 1'b1, 8'd0, 1'b0);
        repeat (7) @(posedge clock);
        #1;
        check("tmo_not_yet_err", error0, 1'b0);
        check("tmo_not_yet_busy", busy0, 1'b1);
        @(posedge clock);
        #1;
        check_status("timeout", 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);

        // Restart after timeout with a one-byte frame.
        pulse_start();
        send(8'h01, 1'b0, 8'd0, 1'b0);
        send(8'h5A, 1'b1, 8'd0, 1'b0);
        send(8'h5A, 1'b0, 8'd0, 1'b0);
        check_status("restart", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);

        // Start while busy must be ignored: frame continues at the same address.
        pulse_start();
        send(8'h02, 1'b0, 8'd0, 1'b0);
        send(8'h10, 1'b1, 8'd0, 1'b0);
        pulse_start();
        check("busy_start_busy", busy0, 1'b1);
        check("busy_start_count", count0, 8'd1);
        send(8'h20, 1'b1, 8'd1, 1'b0);
        send(8'h30, 1'b0, 8'd0, 1'b0);
        check_status("busystart", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);

        // Reset mid-frame after two payload bytes.
        pulse_start();
        send(8'h03, 1'b0, 8'd0, 1'b0);
        send(8'h01, 1'b1, 8'd0, 1'b0);
        send(8'h02, 1'b1, 8'd1, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check_status("postrst", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

        repeat (3) @(negedge clock);
        check("pending_wr0", q0.size(), 16'd0);
        check("pending_wr1", q1.size(), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
